mem_arbiter: RTL and testbench

Sequencing controller and two-port arbiter in front of the single-port word memory. Shares the memory between the instruction-fetch port (read-only) and the data port (load/store), and converts each accepted request into the memory's edge-triggered `en_mem` strobe protocol. Returns read data with a completion pulse. Sits between the fetch/LSU stages and the memory instance.

---
 rtl/mem_ctrl_pkg.sv | 5 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state and owner encodings for the memory sequencer
package mem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, CAPTURE, RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; ports clk_i, rst_i, req_i[1:0], adv_i, gnt_o[1:0]
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
    gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);
    last_d   = adv_i ? gnt_o[1] : last_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: IF/DM round-robin arbiter sequencing accesses to a strobe-driven single-port memory
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_req_i,
  input  logic [WORD_SIZE-1:0] if_addr_i,
  output logic                 if_gnt_o,
  output logic                 if_done_o,
  output logic [WORD_SIZE-1:0] if_rdata_o,
  input  logic                 dm_req_i,
  input  logic                 dm_we_i,
  input  logic [WORD_SIZE-1:0] dm_addr_base_i,
  input  logic [WORD_SIZE-1:0] dm_addr_offset_i,
  input  logic [WORD_SIZE-1:0] dm_wdata_i,
  output logic                 dm_gnt_o,
  output logic                 dm_done_o,
  output logic [WORD_SIZE-1:0] dm_rdata_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 en_mem_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [WORD_SIZE-1:0] addr_base_o,
  output logic [WORD_SIZE-1:0] addr_offset_o,
  output logic [WORD_SIZE-1:0] val_o,
  input  logic [WORD_SIZE-1:0] val_i
);
  state_e               state_q;
  owner_e               owner_q;
  logic                 we_q, err_q, oob, active;
  logic [1:0]           gnt;
  logic [WORD_SIZE-1:0] base_q, off_q, wdata_q, if_rdata_q, dm_rdata_q;
  rr_arbiter2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({dm_req_i, if_req_i} & {2{state_q == IDLE}}),
    .adv_i (|gnt),
    .gnt_o (gnt)
  );
  always_comb begin
    oob           = (base_q + off_q) >= WORD_SIZE'(MEM_SIZE);
    active        = state_q inside {SETUP, STROBE, CAPTURE};
    if_gnt_o      = gnt[0];
    dm_gnt_o      = gnt[1];
    if_done_o     = state_q == RESP && owner_q == OWN_IF;
    dm_done_o     = state_q == RESP && owner_q == OWN_DM;
    err_o         = state_q == RESP && err_q;
    busy_o        = state_q != IDLE;
    en_mem_o      = state_q == STROBE;
    mem_read_o    = active & ~we_q;
    mem_write_o   = active & we_q;
    addr_base_o   = base_q;
    addr_offset_o = off_q;
    val_o         = wdata_q;
    if_rdata_o    = if_rdata_q;
    dm_rdata_o    = dm_rdata_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      base_q     <= '0;
      off_q      <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (gnt[0]) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            base_q  <= if_addr_i;
            off_q   <= '0;
            state_q <= SETUP;
          end else if (gnt[1]) begin
            owner_q <= OWN_DM;
            we_q    <= dm_we_i;
            base_q  <= dm_addr_base_i;
            off_q   <= dm_addr_offset_i;
            wdata_q <= dm_wdata_i;
            state_q <= SETUP;
          end
        SETUP: begin
          err_q   <= oob;
          state_q <= oob ? RESP : STROBE;
        end
        STROBE: state_q <= CAPTURE;
        CAPTURE: begin
          if (!we_q && owner_q == OWN_IF) if_rdata_q <= val_i;
          if (!we_q && owner_q == OWN_DM) dm_rdata_q <= val_i;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a strobe-edge memory model
module tb_mem_arbiter;
  logic        clk_i = 0, rst_i = 1;
  logic        if_req_i = 0, dm_req_i = 0, dm_we_i = 0;
  logic [31:0] if_addr_i = 0, dm_addr_base_i = 0, dm_addr_offset_i = 0, dm_wdata_i = 0, val_i = 0;
  logic        if_gnt_o, if_done_o, dm_gnt_o, dm_done_o, err_o, busy_o, en_mem_o, mem_read_o, mem_write_o;
  logic [31:0] if_rdata_o, dm_rdata_o, addr_base_o, addr_offset_o, val_o;
  logic [31:0] mem [1024];
  logic [31:0] ma;
  int          en_cnt = 0, checks = 0, failures = 0;
  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o), .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_base_i(dm_addr_base_i), .dm_addr_offset_i(dm_addr_offset_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o),
    .err_o(err_o), .busy_o(busy_o), .en_mem_o(en_mem_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .addr_base_o(addr_base_o), .addr_offset_o(addr_offset_o), .val_o(val_o), .val_i(val_i)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge en_mem_o) begin
    en_cnt++;
    ma = addr_base_o + addr_offset_o;
    if (mem_write_o) mem[ma[9:0]] = val_o;
    else val_i = mem[ma[9:0]];
  end
  task automatic step;
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset;
    step;
    step;
    checks++;
    if ({if_gnt_o, if_done_o, dm_gnt_o, dm_done_o, err_o, busy_o, en_mem_o, mem_read_o, mem_write_o} !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl got %b exp 0", {if_gnt_o, if_done_o, dm_gnt_o, dm_done_o, err_o, busy_o, en_mem_o, mem_read_o, mem_write_o});
    end
    checks++;
    if ({addr_base_o, addr_offset_o, val_o, if_rdata_o, dm_rdata_o} !== 160'd0) begin
      failures++;
      $display("FAIL reset_data got %h exp 0", {addr_base_o, addr_offset_o, val_o, if_rdata_o, dm_rdata_o});
    end
    rst_i = 0;
    step;
  endtask
  task automatic test_fetch;
    int c0 = en_cnt;
    if_req_i = 1; if_addr_i = 5;
    #1;
    checks++;
    if ({if_gnt_o, dm_gnt_o} !== 2'b10) begin failures++; $display("FAIL fetch_gnt got %b exp 10", {if_gnt_o, dm_gnt_o}); end
    step; if_req_i = 0;
    checks++;
    if ({en_mem_o, mem_read_o, mem_write_o, addr_base_o, addr_offset_o} !== {3'b010, 32'd5, 32'd0}) begin
      failures++; $display("FAIL fetch_setup got %h exp 2_00000005_00000000", {en_mem_o, mem_read_o, mem_write_o, addr_base_o, addr_offset_o});
    end
    step;
    checks++;
    if (en_mem_o !== 1'b1) begin failures++; $display("FAIL fetch_strobe got %b exp 1", en_mem_o); end
    step;
    checks++;
    if ({en_mem_o, if_done_o} !== 2'b00) begin failures++; $display("FAIL fetch_capture got %b exp 00", {en_mem_o, if_done_o}); end
    step;
    checks++;
    if ({if_done_o, dm_done_o, err_o, if_rdata_o} !== {3'b100, 32'hDEADBEEF}) begin
      failures++; $display("FAIL fetch_done got %h exp 4_deadbeef", {if_done_o, dm_done_o, err_o, if_rdata_o});
    end
    step;
    checks++;
    if ({if_done_o, busy_o, en_cnt - c0} !== {2'b00, 32'd1}) begin
      failures++; $display("FAIL fetch_end got done=%b busy=%b pulses=%0d exp 0 0 1", if_done_o, busy_o, en_cnt - c0);
    end
  endtask
  task automatic test_store_load;
    dm_req_i = 1; dm_we_i = 1; dm_addr_base_i = 100; dm_addr_offset_i = 4; dm_wdata_i = 32'h1234;
    #1;
    checks++;
    if ({if_gnt_o, dm_gnt_o, mem_write_o} !== 3'b010) begin failures++; $display("FAIL store_gnt got %b exp 010", {if_gnt_o, dm_gnt_o, mem_write_o}); end
    for (int c = 1; c <= 4; c++) begin
      step; dm_req_i = 0;
      checks++;
      if (mem_write_o !== (c != 4)) begin failures++; $display("FAIL store_write_c%0d got %b exp %b", c, mem_write_o, c != 4); end
    end
    checks++;
    if ({dm_done_o, err_o, mem[104]} !== {2'b10, 32'h1234}) begin
      failures++; $display("FAIL store_done got %h exp 2_00001234", {dm_done_o, err_o, mem[104]});
    end
    step;
    dm_req_i = 1; dm_we_i = 0;
    #1;
    checks++;
    if (dm_gnt_o !== 1'b1) begin failures++; $display("FAIL load_gnt got %b exp 1", dm_gnt_o); end
    for (int c = 1; c <= 4; c++) begin
      step; dm_req_i = 0;
      checks++;
      if (mem_write_o !== 1'b0) begin failures++; $display("FAIL load_write_c%0d got %b exp 0", c, mem_write_o); end
    end
    checks++;
    if ({dm_done_o, err_o, dm_rdata_o} !== {2'b10, 32'h1234}) begin
      failures++; $display("FAIL load_done got %h exp 2_00001234", {dm_done_o, err_o, dm_rdata_o});
    end
    step;
  endtask
  task automatic test_round_robin;
    if_req_i = 1; if_addr_i = 5;
    dm_req_i = 1; dm_we_i = 0; dm_addr_base_i = 104; dm_addr_offset_i = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if ({if_gnt_o, dm_gnt_o} !== {c % 10 == 0, c % 10 == 5}) begin
        failures++; $display("FAIL rr_c%0d got %b exp %b", c, {if_gnt_o, dm_gnt_o}, {c % 10 == 0, c % 10 == 5});
      end
      if (c == 19) begin if_req_i = 0; dm_req_i = 0; end
      step;
    end
  endtask
  task automatic test_error;
    int c0 = en_cnt;
    dm_req_i = 1; dm_we_i = 0; dm_addr_base_i = 1000; dm_addr_offset_i = 30;
    #1;
    checks++;
    if (dm_gnt_o !== 1'b1) begin failures++; $display("FAIL err_gnt got %b exp 1", dm_gnt_o); end
    step; dm_req_i = 0;
    checks++;
    if ({en_mem_o, dm_done_o} !== 2'b00) begin failures++; $display("FAIL err_setup got %b exp 00", {en_mem_o, dm_done_o}); end
    step;
    checks++;
    if ({dm_done_o, err_o, en_mem_o, dm_rdata_o, en_cnt - c0} !== {3'b110, 32'h1234, 32'd0}) begin
      failures++; $display("FAIL err_done got done=%b err=%b en=%b rdata=%h pulses=%0d exp 1 1 0 1234 0", dm_done_o, err_o, en_mem_o, dm_rdata_o, en_cnt - c0);
    end
    step;
    checks++;
    if ({busy_o, err_o, dm_done_o} !== 3'b000) begin failures++; $display("FAIL err_end got %b exp 000", {busy_o, err_o, dm_done_o}); end
  endtask
  task automatic test_wrap;
    dm_req_i = 1; dm_we_i = 0; dm_addr_base_i = 2; dm_addr_offset_i = 32'hFFFFFFFF;
    #1;
    step; dm_req_i = 0;
    step;
    checks++;
    if (en_mem_o !== 1'b1) begin failures++; $display("FAIL wrap_strobe got %b exp 1", en_mem_o); end
    step; step;
    checks++;
    if ({dm_done_o, err_o, dm_rdata_o} !== {2'b10, 32'h0000A5A5}) begin
      failures++; $display("FAIL wrap_done got %h exp 2_0000a5a5", {dm_done_o, err_o, dm_rdata_o});
    end
    step;
  endtask
  task automatic test_reset_mid;
    dm_req_i = 1; dm_we_i = 1; dm_addr_base_i = 200; dm_addr_offset_i = 0; dm_wdata_i = 32'hCAFE;
    #1;
    step; dm_req_i = 0;
    step;
    checks++;
    if (en_mem_o !== 1'b1) begin failures++; $display("FAIL rstmid_strobe got %b exp 1", en_mem_o); end
    #2 rst_i = 1;
    #1;
    checks++;
    if ({en_mem_o, busy_o, mem_write_o, dm_done_o, addr_base_o, val_o} !== 68'd0) begin
      failures++; $display("FAIL rstmid_async got %h exp 0", {en_mem_o, busy_o, mem_write_o, dm_done_o, addr_base_o, val_o});
    end
    checks++;
    if (mem[200] !== 32'hCAFE) begin failures++; $display("FAIL rstmid_commit got %h exp cafe", mem[200]); end
    step; rst_i = 0;
    for (int c = 0; c < 3; c++) begin
      step;
      checks++;
      if ({dm_done_o, if_done_o, busy_o} !== 3'b000) begin failures++; $display("FAIL rstmid_quiet_c%0d got %b exp 000", c, {dm_done_o, if_done_o, busy_o}); end
    end
    if_req_i = 1; if_addr_i = 5;
    #1;
    checks++;
    if (if_gnt_o !== 1'b1) begin failures++; $display("FAIL rstmid_next_gnt got %b exp 1", if_gnt_o); end
    step; if_req_i = 0;
    step; step; step;
    checks++;
    if ({if_done_o, err_o, if_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
      failures++; $display("FAIL rstmid_next_done got %h exp 2_deadbeef", {if_done_o, err_o, if_rdata_o});
    end
    step;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hDEADBEEF;
    mem[1] = 32'h0000A5A5;
    test_reset;
    test_fetch;
    test_store_load;
    test_round_robin;
    test_error;
    test_wrap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
